// File: rtl/mp_add_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mp_add_pkg : shared word width and sequencer state encoding
// Revision   : 1.0  initial release
// ---------------------------------------------------------------------------
package mp_add_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/cbadder32.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cbadder32 : 32-bit carry-bypass adder (4-bit ripple blocks with skip)
// Revision  : 1.0  initial release
// ---------------------------------------------------------------------------
module cbadder32
  import mp_add_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              cin,
  output logic [WORD_W-1:0] sum,
  output logic              cout
);

  localparam int BLK_W = 4;
  localparam int N_BLK = WORD_W / BLK_W;

  logic c;
  logic c_blk_in;
  logic p;
  logic p_blk;

  // A block whose bits all propagate passes its incoming carry straight through.
  always_comb begin
    sum      = '0;
    c        = cin;
    c_blk_in = 1'b0;
    p        = 1'b0;
    p_blk    = 1'b0;
    for (int blk = 0; blk < N_BLK; blk++) begin
      c_blk_in = c;
      p_blk    = 1'b1;
      for (int j = 0; j < BLK_W; j++) begin
        p                  = a[blk*BLK_W + j] ^ b[blk*BLK_W + j];
        sum[blk*BLK_W + j] = p ^ c;
        c                  = (a[blk*BLK_W + j] & b[blk*BLK_W + j]) | (p & c);
        p_blk              = p_blk & p;
      end
      if (p_blk) begin
        c = c_blk_in;
      end
    end
    cout = c;
  end

endmodule
`default_nettype wire

// File: rtl/mp_add_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mp_add_seq : multi-precision add/subtract, one 32-bit word per cycle, LSW first
// Revision   : 1.0  initial release
// ---------------------------------------------------------------------------
module mp_add_seq
  import mp_add_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WORD_W*WORDS-1:0] op_a,
  input  logic [WORD_W*WORDS-1:0] op_b,
  input  logic                    sub,
  input  logic                    cin,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WORD_W*WORDS-1:0] result,
  output logic                    cout,
  output logic                    overflow
);

  localparam int IDX_W = $clog2(WORDS);

  state_t                       state;
  state_t                       state_nxt;
  logic                         armed;
  logic [WORDS-1:0][WORD_W-1:0] a_q;
  logic [WORDS-1:0][WORD_W-1:0] b_q;
  logic [WORDS-1:0][WORD_W-1:0] res_q;
  logic [IDX_W-1:0]             idx;
  logic                         carry;
  logic                         cout_q;
  logic                         ovf_q;
  logic [WORD_W-1:0]            add_sum;
  logic                         add_cout;
  logic                         last;
  logic                         accept;

  cbadder32 u_add (
    .a    (a_q[idx]),
    .b    (b_q[idx]),
    .cin  (carry),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign last   = (idx == IDX_W'(WORDS - 1));
  assign accept = in_valid && in_ready;

  assign result   = res_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

  always_comb begin
    state_nxt = state;
    // armed keeps in_ready low until the first clock after reset release
    in_ready  = armed && (state == IDLE);
    out_valid = (state == DONE);
    case (state)
      IDLE:    if (in_valid && in_ready) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      idx    <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      armed <= 1'b1;
      if (state == IDLE && accept) begin
        a_q   <= op_a;
        b_q   <= sub ? ~op_b : op_b;
        carry <= sub ? 1'b1 : cin;
        idx   <= '0;
      end
      if (state == RUN) begin
        res_q[idx] <= add_sum;
        carry      <= add_cout;
        if (last) begin
          cout_q <= add_cout;
          ovf_q  <= (a_q[idx][WORD_W-1] == b_q[idx][WORD_W-1]) &&
                    (add_sum[WORD_W-1] != a_q[idx][WORD_W-1]);
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mp_add_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mp_add_seq : directed vector bench for mp_add_seq (WORDS=4 and WORDS=2)
// Revision      : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_mp_add_seq;

  localparam int W = 4;
  localparam logic [127:0] ONES = {128{1'b1}};
  localparam logic [127:0] MSB  = {1'b1, 127'b0};

  typedef struct {
    logic [127:0] a;
    logic [127:0] b;
    logic         sub;
    logic         cin;
    logic [127:0] res;
    logic         co;
    logic         ov;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] op_a = '0;
  logic [127:0] op_b = '0;
  logic         sub = 1'b0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] result;
  logic         cout;
  logic         overflow;

  logic         rst2_n = 1'b0;
  logic         in_valid2 = 1'b0;
  logic         in_ready2;
  logic [63:0]  op_a2 = '0;
  logic [63:0]  op_b2 = '0;
  logic         out_valid2;
  logic         out_ready2 = 1'b0;
  logic [63:0]  result2;
  logic         cout2;
  logic         overflow2;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mp_add_seq #(.WORDS(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .sub(sub), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout), .overflow(overflow)
  );

  mp_add_seq #(.WORDS(2)) dut2 (
    .clk(clk), .rst_n(rst2_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .op_a(op_a2), .op_b(op_b2), .sub(1'b0), .cin(1'b0),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .result(result2), .cout(cout2), .overflow(overflow2)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    for (int i = 0; i < 20 && !in_ready; i++) tick();
    check({name, " ready"}, 128'(in_ready), 128'd1);
  endtask

  // Returns number of edges after the accept edge until out_valid rises (0 = timeout).
  task automatic wait_valid(output int lat);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic drive(input vec_t v);
    op_a = v.a;
    op_b = v.b;
    sub  = v.sub;
    cin  = v.cin;
  endtask

  task automatic run_op(input vec_t v, input string name);
    int lat;
    wait_ready(name);
    drive(v);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    op_a = ~op_a;
    op_b = ~op_b;
    sub  = ~sub;
    cin  = ~cin;
    wait_valid(lat);
    check({name, " latency"}, 128'(lat), 128'(W));
    check({name, " result"}, result, v.res);
    check({name, " cout"}, 128'(cout), 128'(v.co));
    check({name, " overflow"}, 128'(overflow), 128'(v.ov));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, " valid drop"}, 128'(out_valid), 128'd0);
    check({name, " ready back"}, 128'(in_ready), 128'd1);
  endtask

  vec_t vecs[9];

  initial begin
    int lat;
    vecs[0] = '{ONES, 128'd1, 1'b0, 1'b0, 128'd0, 1'b1, 1'b0};
    vecs[1] = '{128'd0, 128'd1, 1'b1, 1'b0, ONES, 1'b0, 1'b0};
    vecs[2] = '{~MSB, 128'd1, 1'b0, 1'b0, MSB, 1'b0, 1'b1};
    vecs[3] = '{MSB, 128'd1, 1'b1, 1'b0, ~MSB, 1'b1, 1'b1};
    vecs[4] = '{128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, 128'd0, 1'b0, 1'b1,
                128'h0000_0000_0000_0001_0000_0000_0000_0000, 1'b0, 1'b0};
    vecs[5] = '{128'd5, 128'd3, 1'b1, 1'b1, 128'd2, 1'b1, 1'b0};
    vecs[6] = '{128'h0123456789ABCDEF_FEDCBA9876543210, 128'h1111111111111111_1111111111111111,
                1'b0, 1'b0, 128'h123456789ABCDF01_0FEDCBA987654321, 1'b0, 1'b0};
    vecs[7] = '{128'd10, 128'd10, 1'b1, 1'b0, 128'd0, 1'b1, 1'b0};
    vecs[8] = '{MSB, MSB, 1'b0, 1'b0, 128'd0, 1'b1, 1'b1};

    #2;
    check("reset in_ready", 128'(in_ready), 128'd0);
    check("reset out_valid", 128'(out_valid), 128'd0);
    check("reset result", result, 128'd0);
    check("reset cout", 128'(cout), 128'd0);
    check("reset overflow", 128'(overflow), 128'd0);
    tick();
    check("held reset in_ready", 128'(in_ready), 128'd0);
    rst_n  = 1'b1;
    rst2_n = 1'b1;
    #1;
    check("release before clk in_ready", 128'(in_ready), 128'd0);
    tick();
    check("first clk in_ready", 128'(in_ready), 128'd1);

    for (int i = 0; i < 9; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Result held while consumer stalls; new requests are ignored until IDLE.
    wait_ready("stall");
    drive(vecs[6]);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_valid(lat);
    check("stall latency", 128'(lat), 128'(W));
    op_a = 128'd5; op_b = 128'd7; sub = 1'b0; cin = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall out_valid", 128'(out_valid), 128'd1);
      check("stall in_ready", 128'(in_ready), 128'd0);
      check("stall result", result, vecs[6].res);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("stall release valid", 128'(out_valid), 128'd0);
    check("stall release ready", 128'(in_ready), 128'd1);
    check("stall release retain", result, vecs[6].res);
    tick();
    in_valid = 1'b0;
    check("next accepted", 128'(in_ready), 128'd0);
    wait_valid(lat);
    check("next latency", 128'(lat), 128'(W));
    check("next result", result, 128'd12);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Abort mid-RUN with idx=2.
    wait_ready("abort");
    drive(vecs[6]);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("abort in_ready", 128'(in_ready), 128'd0);
    check("abort out_valid", 128'(out_valid), 128'd0);
    check("abort result", result, 128'd0);
    check("abort cout", 128'(cout), 128'd0);
    check("abort overflow", 128'(overflow), 128'd0);
    tick();
    rst_n = 1'b1;
    check("abort no valid", 128'(out_valid), 128'd0);
    tick();
    run_op(vecs[4], "after abort");

    // WORDS=2 instance: abort mid-RUN, then a full op with cross-word carry.
    op_a2 = 64'h0000_0001_FFFF_FFFF;
    op_b2 = 64'd1;
    in_valid2 = 1'b1;
    tick();
    in_valid2 = 1'b0;
    tick();
    rst2_n = 1'b0;
    #1;
    check("w2 abort valid", 128'(out_valid2), 128'd0);
    check("w2 abort result", 128'(result2), 128'd0);
    check("w2 abort ready", 128'(in_ready2), 128'd0);
    tick();
    rst2_n = 1'b1;
    tick();
    check("w2 ready", 128'(in_ready2), 128'd1);
    in_valid2 = 1'b1;
    tick();
    in_valid2 = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (out_valid2) begin
        lat = i;
        break;
      end
    end
    check("w2 latency", 128'(lat), 128'd2);
    check("w2 result", 128'(result2), 128'h0000_0002_0000_0000);
    check("w2 cout", 128'(cout2), 128'd0);
    check("w2 overflow", 128'(overflow2), 128'd0);
    out_ready2 = 1'b1;
    tick();
    out_ready2 = 1'b0;
    check("w2 valid drop", 128'(out_valid2), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
